ps2_key_token_decoder: RTL and testbench

Converts the raw PS/2 scan-code byte stream from the keyboard receiver into calculator key tokens, buffered in a small FIFO with a ready/valid output. It sits between the PS/2 byte receiver and the calculator stack/display logic. It handles the E0 extended and F0 break prefixes, skips the E1 Pause sequence, suppresses typematic auto-repeat, and maps each accepted make code to a token.

---
 rtl/ps2_key_token_decoder.sv | 221 ++++++++++++++++++++++
 tb/tb_ps2_key_token_decoder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ps2_key_token_decoder.sv
// PS/2 scan-code parser, calculator key mapper with repeat suppression, and
// token FIFO. The decode result is registered once before it reaches the FIFO.
module ps2_key_token_decoder #(
  parameter int DEPTH = 8
) (
  input  logic       CLK_25M,
  input  logic       Reset_n,
  input  logic [7:0] Scan_Code,
  input  logic       Scan_Valid,
  input  logic       Token_Ready,
  input  logic       Clear_Overflow,
  output logic       Token_Valid,
  output logic [2:0] Token_Kind,
  output logic [3:0] Token_Value,
  output logic       Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  localparam logic [2:0] K_DIG = 3'd0, K_ADD = 3'd1, K_SUB = 3'd2, K_MUL = 3'd3,
                         K_ENT = 3'd4, K_BS  = 3'd5, K_CLR = 3'd6;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        mk, brk, ext;
  logic [7:0]  map_r;

  logic        ev_make_q, ev_brk_q;
  logic [8:0]  ev_key_q;
  logic [6:0]  ev_tok_q;

  logic [8:0]  held_q, held_d;
  logic        held_vld_q, held_vld_d;
  logic        held_hit, tok_push;

  logic [6:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full, push, pop;
  logic        ovf_q, ovf_d;

  // Returns {hit, kind[2:0], value[3:0]}.
  function automatic logic [7:0] map_code(input logic e, input logic [7:0] c);
    logic [7:0] r;
    r = 8'h00;
    if (e) begin
      if (c == 8'h5A) r = {1'b1, K_ENT, 4'h0};
    end else begin
      case (c)
        8'h45: r = {1'b1, K_DIG, 4'h0};
        8'h16: r = {1'b1, K_DIG, 4'h1};
        8'h1E: r = {1'b1, K_DIG, 4'h2};
        8'h26: r = {1'b1, K_DIG, 4'h3};
        8'h25: r = {1'b1, K_DIG, 4'h4};
        8'h2E: r = {1'b1, K_DIG, 4'h5};
        8'h36: r = {1'b1, K_DIG, 4'h6};
        8'h3D: r = {1'b1, K_DIG, 4'h7};
        8'h3E: r = {1'b1, K_DIG, 4'h8};
        8'h46: r = {1'b1, K_DIG, 4'h9};
        8'h1C: r = {1'b1, K_DIG, 4'hA};
        8'h32: r = {1'b1, K_DIG, 4'hB};
        8'h21: r = {1'b1, K_DIG, 4'hC};
        8'h23: r = {1'b1, K_DIG, 4'hD};
        8'h24: r = {1'b1, K_DIG, 4'hE};
        8'h2B: r = {1'b1, K_DIG, 4'hF};
        8'h55, 8'h79: r = {1'b1, K_ADD, 4'h0};
        8'h4E, 8'h7B: r = {1'b1, K_SUB, 4'h0};
        8'h7C: r = {1'b1, K_MUL, 4'h0};
        8'h5A: r = {1'b1, K_ENT, 4'h0};
        8'h66: r = {1'b1, K_BS,  4'h0};
        8'h76: r = {1'b1, K_CLR, 4'h0};
        default: r = 8'h00;
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge CLK_25M or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mk      = 1'b0;
    brk     = 1'b0;
    ext     = 1'b0;
    if (Scan_Valid) begin
      case (state_q)
        IDLE: begin
          case (Scan_Code)
            8'hE0: state_d = EXT;
            8'hF0: state_d = BRK;
            8'hE1: begin
              state_d = SKIP;
              cnt_d   = 3'd7;
            end
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
            default: mk = 1'b1;
          endcase
        end
        EXT: begin
          if (Scan_Code == 8'hF0) begin
            state_d = EXT_BRK;
          end else begin
            mk      = 1'b1;
            ext     = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          brk     = 1'b1;
          state_d = IDLE;
        end
        EXT_BRK: begin
          brk     = 1'b1;
          ext     = 1'b1;
          state_d = IDLE;
        end
        SKIP: begin
          // Pause is E1 plus seven more bytes; leave on the seventh.
          if (cnt_q <= 3'd1) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign map_r = map_code(ext, Scan_Code);

  // Unmapped makes never reach the held register, so only mapped ones register.
  always_ff @(posedge CLK_25M or negedge Reset_n) begin
    if (!Reset_n) begin
      ev_make_q <= 1'b0;
      ev_brk_q  <= 1'b0;
      ev_key_q  <= '0;
      ev_tok_q  <= '0;
    end else begin
      ev_make_q <= mk & map_r[7];
      ev_brk_q  <= brk;
      ev_key_q  <= {ext, Scan_Code};
      ev_tok_q  <= map_r[6:0];
    end
  end

  assign held_hit = held_vld_q && (held_q == ev_key_q);
  assign tok_push = ev_make_q && !held_hit;

  always_comb begin
    held_d     = held_q;
    held_vld_d = held_vld_q;
    if (tok_push) begin
      held_d     = ev_key_q;
      held_vld_d = 1'b1;
    end else if (ev_brk_q && held_hit) begin
      held_vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_25M or negedge Reset_n) begin
    if (!Reset_n) begin
      held_q     <= '0;
      held_vld_q <= 1'b0;
    end else begin
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && Token_Ready;
  assign push  = tok_push && (!full || pop);

  always_ff @(posedge CLK_25M) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= ev_tok_q;
  end

  always_ff @(posedge CLK_25M or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (Clear_Overflow) ovf_d = 1'b0;
    if (tok_push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK_25M or negedge Reset_n) begin
    if (!Reset_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end

  // Head is masked when empty so outputs read zero out of reset.
  assign Token_Valid = !empty;
  assign Token_Kind  = empty ? 3'd0 : mem[rd_ptr_q[AW-1:0]][6:4];
  assign Token_Value = empty ? 4'd0 : mem[rd_ptr_q[AW-1:0]][3:0];
  assign Overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_key_token_decoder.sv
// Directed table-driven bench for ps2_key_token_decoder plus hand sequences
// for latency, FIFO overflow/drain and mid-sequence reset.
module tb_ps2_key_token_decoder;

  logic       CLK_25M, Reset_n;
  logic [7:0] Scan_Code;
  logic       Scan_Valid, Token_Ready, Clear_Overflow;
  logic       Token_Valid;
  logic [2:0] Token_Kind;
  logic [3:0] Token_Value;
  logic       Overflow;

  ps2_key_token_decoder #(.DEPTH(8)) dut (
    .CLK_25M(CLK_25M), .Reset_n(Reset_n), .Scan_Code(Scan_Code),
    .Scan_Valid(Scan_Valid), .Token_Ready(Token_Ready),
    .Clear_Overflow(Clear_Overflow), .Token_Valid(Token_Valid),
    .Token_Kind(Token_Kind), .Token_Value(Token_Value), .Overflow(Overflow)
  );

  initial CLK_25M = 1'b0;
  always #5 CLK_25M = ~CLK_25M;

  typedef struct packed {
    logic [9:0][7:0] b;     // b[9] is sent first
    logic [3:0]      n;
    logic [2:0]      ntok;
    logic [3:0][6:0] t;     // t[3] is the first token, {kind,value}
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  int total = 0, passed = 0;
  logic [6:0] got [$];

  always @(negedge CLK_25M)
    if (Reset_n && Token_Valid && Token_Ready) got.push_back({Token_Kind, Token_Value});

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic put(input logic [7:0] b);
    Scan_Code  = b;
    Scan_Valid = 1'b1;
    @(posedge CLK_25M); #1;
    Scan_Valid = 1'b0;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0; Scan_Valid = 1'b0; Scan_Code = 8'h00;
    Token_Ready = 1'b0; Clear_Overflow = 1'b0;
    repeat (2) @(posedge CLK_25M);
    #1 Reset_n = 1'b1;
    got.delete();
  endtask

  // Nine distinct digits 1..9, each followed by its break.
  task automatic fill9();
    logic [7:0] codes [9];
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 9; i++) begin
      put(codes[i]); put(8'hF0); put(codes[i]);
    end
    repeat (4) @(posedge CLK_25M); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{b:{8'h16, 72'h0}, n:4'd1, ntok:3'd1, t:{7'h01, 21'h0}};
    vecs[1]  = '{b:{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C, 32'h0}, n:4'd6, ntok:3'd2, t:{7'h0A, 7'h0A, 14'h0}};
    vecs[2]  = '{b:{8'hE0, 8'h5A, 64'h0}, n:4'd2, ntok:3'd1, t:{7'h40, 21'h0}};
    vecs[3]  = '{b:{8'hE0, 8'h4A, 64'h0}, n:4'd2, ntok:3'd0, t:28'h0};
    vecs[4]  = '{b:{8'hE0, 8'h5A, 8'hE0, 8'hF0, 8'h5A, 8'hE0, 8'h5A, 24'h0}, n:4'd7, ntok:3'd2, t:{7'h40, 7'h40, 14'h0}};
    vecs[5]  = '{b:{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h55, 8'h00}, n:4'd9, ntok:3'd1, t:{7'h10, 21'h0}};
    vecs[6]  = '{b:{8'h7B, 8'h7C, 8'h66, 8'h76, 48'h0}, n:4'd4, ntok:3'd4, t:{7'h20, 7'h30, 7'h50, 7'h60}};
    vecs[7]  = '{b:{8'hAA, 8'hFA, 8'h2B, 56'h0}, n:4'd3, ntok:3'd1, t:{7'h0F, 21'h0}};
    vecs[8]  = '{b:{8'h1C, 8'hF0, 8'h16, 8'h1C, 48'h0}, n:4'd4, ntok:3'd1, t:{7'h0A, 21'h0}};
    vecs[9]  = '{b:{8'h5A, 8'h33, 8'h5A, 56'h0}, n:4'd3, ntok:3'd1, t:{7'h40, 21'h0}};
    vecs[10] = '{b:{8'hE0, 8'h1C, 64'h0}, n:4'd2, ntok:3'd0, t:28'h0};
    vecs[11] = '{b:{8'h45, 8'h79, 8'h4E, 56'h0}, n:4'd3, ntok:3'd3, t:{7'h00, 7'h10, 7'h20, 7'h0}};

    // Reset state and first-token latency
    do_reset();
    chk("rst_valid", Token_Valid, 0);
    chk("rst_kind", Token_Kind, 0);
    chk("rst_value", Token_Value, 0);
    chk("rst_ovf", Overflow, 0);
    Scan_Code = 8'h16; Scan_Valid = 1'b1;
    @(posedge CLK_25M); #1 Scan_Valid = 1'b0;
    chk("lat_n1_valid", Token_Valid, 0);
    @(posedge CLK_25M); #1;
    chk("lat_n2_valid", Token_Valid, 1);
    chk("lat_n2_tok", {Token_Kind, Token_Value}, 7'h01);

    // Table-driven sequences, each from a fresh reset
    for (int v = 0; v < NV; v++) begin
      do_reset();
      Token_Ready = 1'b1;
      for (int i = 0; i < int'(vecs[v].n); i++) put(vecs[v].b[9-i]);
      repeat (8) @(posedge CLK_25M); #1;
      chk($sformatf("vec%0d_count", v), got.size(), int'(vecs[v].ntok));
      for (int i = 0; i < int'(vecs[v].ntok); i++)
        chk($sformatf("vec%0d_tok%0d", v, i),
            (i < got.size()) ? got[i] : 7'h7F, vecs[v].t[3-i]);
    end

    // FIFO full: 9 tokens into 8 entries, head stable, drain in order
    do_reset();
    fill9();
    chk("full_valid", Token_Valid, 1);
    chk("full_ovf", Overflow, 1);
    chk("full_head", {Token_Kind, Token_Value}, 7'h01);
    repeat (3) @(posedge CLK_25M); #1;
    chk("full_head_stable", {Token_Kind, Token_Value}, 7'h01);
    Token_Ready = 1'b1;
    repeat (12) @(posedge CLK_25M); #1;
    chk("drain_count", got.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("drain_tok%0d", i), (i < got.size()) ? got[i] : 7'h7F, i + 1);
    chk("drain_empty", Token_Valid, 0);
    chk("ovf_sticky", Overflow, 1);
    Clear_Overflow = 1'b1;
    @(posedge CLK_25M); #1 Clear_Overflow = 1'b0;
    chk("ovf_cleared", Overflow, 0);

    // Mid-sequence reset: outputs zero during reset, pending F0 discarded
    do_reset();
    fill9();
    put(8'hF0);
    Reset_n = 1'b0;
    #2;
    chk("midrst_valid", Token_Valid, 0);
    chk("midrst_kind", Token_Kind, 0);
    chk("midrst_value", Token_Value, 0);
    chk("midrst_ovf", Overflow, 0);
    @(posedge CLK_25M); #1 Reset_n = 1'b1;
    got.delete();
    Token_Ready = 1'b1;
    put(8'h16);
    repeat (6) @(posedge CLK_25M); #1;
    chk("midrst_count", got.size(), 1);
    chk("midrst_tok", (got.size() > 0) ? got[0] : 7'h7F, 7'h01);
    chk("midrst_ovf_after", Overflow, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
